// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: lookup, training, flush and prediction signals of the branch target buffer
interface branch_target_buffer_if;
  logic        w_ce;
  logic [31:0] w_lookup_pc;
  logic        w_upd_valid;
  logic [31:0] w_upd_pc;
  logic        w_upd_taken;
  logic [31:0] w_upd_target;
  logic        w_flush;
  logic        r_pred_hit;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;
  logic        r_busy;
  modport slave (
    input  w_ce, w_lookup_pc, w_upd_valid, w_upd_pc, w_upd_taken, w_upd_target, w_flush,
    output r_pred_hit, r_pred_taken, r_pred_target, r_busy
  );
  modport master (
    output w_ce, w_lookup_pc, w_upd_valid, w_upd_pc, w_upd_taken, w_upd_target, w_flush,
    input  r_pred_hit, r_pred_taken, r_pred_target, r_busy
  );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: tagged direct-mapped BTB with saturating counters and sequenced flush; define BTB_FWD_EN to forward same-edge updates to the lookup
module branch_target_buffer #(
  parameter int ENTRIES  = 64,
  parameter int TAG_W    = 8,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2
) (
  input logic w_clk,
  input logic w_rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic               hit_q, hit_d, taken_q, taken_d;
  logic [31:0]        target_q, target_d;
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic [CTR_W-1:0]   u_ctr, new_ctr;
  logic [31:0]        new_tgt;
  logic               l_hit, u_hit, wr, mute, fwd, unused_pc;
  assign l_idx = bus.w_lookup_pc[IDX_W+1:2];
  assign l_tag = bus.w_lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bus.w_upd_pc[IDX_W+1:2];
  assign u_tag = bus.w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{bus.w_lookup_pc >> (IDX_W+TAG_W+2), bus.w_upd_pc >> (IDX_W+TAG_W+2),
                       bus.w_lookup_pc[1:0], bus.w_upd_pc[1:0]};
  assign l_hit = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_ctr = ctr_q[u_idx];
  assign wr    = bus.w_ce && bus.w_upd_valid && state_q == IDLE && !bus.w_flush &&
                 (u_hit || bus.w_upd_taken);
  assign new_ctr = !u_hit ? CTR_INIT :
                   bus.w_upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + 1'b1) :
                   (u_ctr == '0 ? u_ctr : u_ctr - 1'b1);
  assign new_tgt = bus.w_upd_taken ? bus.w_upd_target : tgt_q[u_idx];
  // the edge that starts a flush already reports a miss so r_busy never coincides with a hit
  assign mute = state_q == FLUSH || bus.w_flush;
`ifdef BTB_FWD_EN
  assign fwd = wr && u_idx == l_idx && u_tag == l_tag;
`else
  assign fwd = 1'b0;
`endif
  always_comb begin
    hit_d    = !mute && (fwd || l_hit);
    taken_d  = hit_d && (fwd ? new_ctr[CTR_W-1] : ctr_q[l_idx][CTR_W-1]);
    target_d = !hit_d ? '0 : fwd ? new_tgt : tgt_q[l_idx];
    valid_d  = valid_q;
    if (state_q == FLUSH) valid_d[fidx_q] = 1'b0;
    else if (wr) valid_d[u_idx] = 1'b1;
    state_d  = state_q == FLUSH ? (fidx_q == IDX_W'(ENTRIES-1) ? IDLE : FLUSH) :
               (bus.w_flush ? FLUSH : IDLE);
    fidx_d   = state_q == FLUSH ? fidx_q + 1'b1 : '0;
  end
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      valid_q  <= '0;
      state_q  <= IDLE;
      fidx_q   <= '0;
      hit_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (bus.w_ce) begin
      valid_q  <= valid_d;
      state_q  <= state_d;
      fidx_q   <= fidx_d;
      hit_q    <= hit_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  always_ff @(posedge w_clk)
    if (wr) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= new_tgt;
      ctr_q[u_idx] <= new_ctr;
    end
  assign bus.r_pred_hit    = hit_q;
  assign bus.r_pred_taken  = taken_q;
  assign bus.r_pred_target = target_q;
  assign bus.r_busy        = state_q == FLUSH;
endmodule
